// File: rtl/ace_xack_pkg.sv
// Shared sizing helpers and default parameters for the ACE acknowledge router.
package ace_xack_pkg;

    localparam int unsigned DefNoMstPorts = 4;
    localparam int unsigned DefMaxTrans   = 8;

    function automatic int unsigned sel_width(input int unsigned no_mst_ports);
        return (no_mst_ports > 1) ? $clog2(no_mst_ports) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_trans);
        return $clog2(max_trans + 1);
    endfunction

endpackage

// File: rtl/ace_xack_fifo.sv
// Single-channel in-order tracker: remembers which master port supplied each
// response and decodes the head entry into a one-hot acknowledge.
module ace_xack_fifo
    import ace_xack_pkg::*;
#(
    parameter int unsigned NoMstPorts  = DefNoMstPorts,
    parameter int unsigned MaxTrans    = DefMaxTrans,
    parameter int unsigned SelectWidth = sel_width(NoMstPorts),
    parameter int unsigned CntWidth    = cnt_width(MaxTrans)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [SelectWidth-1:0] sel_i,
    input  logic                   pop_i,
    output logic [NoMstPorts-1:0]  ack_o,
    output logic                   full_o,
    output logic [CntWidth-1:0]    cnt_o,
    output logic                   err_o
);

    localparam int unsigned PtrWidth = $clog2(MaxTrans);

    logic [SelectWidth-1:0] mem_q [MaxTrans];
    logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   full_q, full_d;
    logic                   empty, push_ok, pop_ok, head_bad;
    logic [SelectWidth-1:0] head;

    function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(MaxTrans - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A pop on an empty tracker is ignored; a push on a full one survives only if a pop frees a slot.
    always_comb begin
        empty    = (cnt_q == '0);
        pop_ok   = pop_i && !empty;
        push_ok  = push_i && (!full_q || pop_ok);
        head     = mem_q[rd_ptr_q];
        head_bad = (32'(head) >= NoMstPorts);

        ack_o = '0;
        for (int unsigned p = 0; p < NoMstPorts; p++) begin
            ack_o[p] = pop_ok && !head_bad && !rst_i && (32'(head) == p);
        end

        err_o = (pop_i && empty) || (push_i && full_q && !pop_ok) || (pop_ok && head_bad);

        wr_ptr_d = push_ok ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? wrap_inc(rd_ptr_q) : rd_ptr_q;

        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == CntWidth'(MaxTrans));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= sel_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = full_q;

endmodule

// File: rtl/ace_xack_router.sv
// Steers slave-side RACK/WACK to the master port that delivered the matching
// response. Define ACE_XACK_REG_OUT_EN to register the acknowledge outputs.
module ace_xack_router
    import ace_xack_pkg::*;
#(
    parameter int unsigned NoMstPorts  = DefNoMstPorts,
    parameter int unsigned MaxTrans    = DefMaxTrans,
    parameter int unsigned SelectWidth = sel_width(NoMstPorts),
    parameter int unsigned CntWidth    = cnt_width(MaxTrans)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   r_done_i,
    input  logic [SelectWidth-1:0] r_sel_i,
    input  logic                   b_done_i,
    input  logic [SelectWidth-1:0] b_sel_i,
    input  logic                   slv_rack_i,
    input  logic                   slv_wack_i,
    output logic [NoMstPorts-1:0]  mst_rack_o,
    output logic [NoMstPorts-1:0]  mst_wack_o,
    output logic                   r_full_o,
    output logic                   b_full_o,
    output logic [CntWidth-1:0]    r_cnt_o,
    output logic [CntWidth-1:0]    b_cnt_o,
    output logic                   err_o
);

    logic [NoMstPorts-1:0] r_ack, b_ack;
    logic                  r_err, b_err;
    logic                  err_q;

    ace_xack_fifo #(
        .NoMstPorts (NoMstPorts),
        .MaxTrans   (MaxTrans),
        .SelectWidth(SelectWidth),
        .CntWidth   (CntWidth)
    ) i_r_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push_i(r_done_i),
        .sel_i (r_sel_i),
        .pop_i (slv_rack_i),
        .ack_o (r_ack),
        .full_o(r_full_o),
        .cnt_o (r_cnt_o),
        .err_o (r_err)
    );

    ace_xack_fifo #(
        .NoMstPorts (NoMstPorts),
        .MaxTrans   (MaxTrans),
        .SelectWidth(SelectWidth),
        .CntWidth   (CntWidth)
    ) i_b_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push_i(b_done_i),
        .sel_i (b_sel_i),
        .pop_i (slv_wack_i),
        .ack_o (b_ack),
        .full_o(b_full_o),
        .cnt_o (b_cnt_o),
        .err_o (b_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | r_err | b_err;
        end
    end

    assign err_o = err_q;

`ifdef ACE_XACK_REG_OUT_EN
    logic [NoMstPorts-1:0] rack_q, wack_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rack_q <= '0;
            wack_q <= '0;
        end else begin
            rack_q <= r_ack;
            wack_q <= b_ack;
        end
    end

    assign mst_rack_o = rack_q;
    assign mst_wack_o = wack_q;
`else
    assign mst_rack_o = r_ack;
    assign mst_wack_o = b_ack;
`endif

endmodule
